shift_sequencer: RTL and testbench

Multi-cycle shift controller for the execute stage. It accepts a shift request (SLL/SRL/SRA) from the datapath control and performs it one bit position per clock on an internal shift register. It reports progress with a start/busy/done handshake so control can stall the pipeline while it runs. The shared single-bit shift resource is used by at most one request at a time.

---
 rtl/shift_sequencer.sv | 125 ++++++++++++
 tb/tb_shift_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA controller for the execute stage.
// A request is latched on an accepted start and shifted one bit per clock.
// A start/busy/done handshake lets control stall the pipeline meanwhile.
// op = 11 is reported as an error and returns the operand unchanged.
module shift_sequencer #(
    parameter int WIDTH     = 32,
    parameter int AMT_WIDTH = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     operand,
    input  logic [AMT_WIDTH-1:0] shamt,
    input  logic [1:0]           op,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [AMT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [1:0]             op_q,    op_d;
    logic                   err_q,   err_d;

    // One-bit shift of the working register for the latched operation.
    logic [WIDTH-1:0]       shreg_step;

    // Single-position shifter: SLL/SRL fill with zero, SRA copies the sign bit.
    always_comb begin
        shreg_step = shreg_q;
        case (op_q)
            OP_SLL:  shreg_step = {shreg_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shreg_step = {1'b0, shreg_q[WIDTH-1:1]};
            OP_SRA:  shreg_step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            default: shreg_step = shreg_q;
        endcase
    end

    // Next-state logic: accept requests in IDLE/DONE, step while in SHIFT.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shreg_d = operand;
                    op_d    = op;
                    cnt_d   = shamt;
                    err_d   = 1'b0;
                    if (op == OP_ILL) begin
                        // Illegal op completes immediately; the amount is ignored.
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else if (shamt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else if (state_q == DONE) begin
                    // DONE is a single-cycle pulse.
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                // Starts are ignored here; there is no request queue.
                shreg_d = shreg_step;
                cnt_d   = cnt_q - AMT_WIDTH'(1);
                if (cnt_q == AMT_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any request in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode directly from state; err only shows with done.
    always_comb begin
        busy   = (state_q == SHIFT);
        ready  = (state_q != SHIFT);
        done   = (state_q == DONE);
        err    = (state_q == DONE) && err_q;
        result = shreg_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a vector table plus hand-written
// multi-cycle sequences, with expected results queued at issue time and
// popped when the DUT raises done.
module tb_shift_sequencer;

    localparam int WIDTH     = 32;
    localparam int AMT_WIDTH = 5;
    localparam int TIMEOUT   = 200;

    logic                 clock;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     operand;
    logic [AMT_WIDTH-1:0] shamt;
    logic [1:0]           op;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [WIDTH-1:0]     result;

    shift_sequencer #(.WIDTH(WIDTH), .AMT_WIDTH(AMT_WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .operand (operand),
        .shamt   (shamt),
        .op      (op),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [31:0] exp_result;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic        err;
        int          lat;
        int          busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Reference model, written independently from the shift-by-one datapath.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [4:0] s);
        logic signed [31:0] sa;
        sa = a;
        case (o)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return sa >>> s;
            default: return a;
        endcase
    endfunction

    // Drive a request; returns at the first sampling point after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        exp_t e;
        e.result      = model(o, a, s);
        e.err         = (o == 2'b11);
        e.lat         = (o == 2'b11 || s == 0) ? 1 : int'(s) + 1;
        e.busy_cycles = (o == 2'b11) ? 0 : int'(s);
        sb.push_back(e);
        start   = 1'b1;
        op      = o;
        operand = a;
        shamt   = s;
        @(negedge clock);
        start   = 1'b0;
    endtask

    // Wait (bounded) for done, then compare against the oldest queued entry.
    task automatic collect(input string name, input int lat0, input int busy0);
        int   lat;
        int   bcnt;
        exp_t e;
        lat  = lat0;
        bcnt = busy0;
        while (!done && lat < TIMEOUT) begin
            if (busy) bcnt++;
            @(negedge clock);
            lat++;
        end
        check({name, " done_seen"}, {31'd0, done}, 32'd1);
        if (sb.size() == 0) begin
            check({name, " sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " latency"}, lat, e.lat);
            check({name, " busy_cycles"}, bcnt, e.busy_cycles);
            check({name, " result"}, result, e.result);
            check({name, " err"}, {31'd0, err}, {31'd0, e.err});
            check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        end
        $display("txn %s: result=0x%08h err=%0b latency=%0d busy=%0d", name, result, err, lat, bcnt);
    endtask

    // done and err must drop one cycle later when no new start arrives.
    task automatic check_pulse_end(input string name);
        @(negedge clock);
        check({name, " done_drop"}, {31'd0, done}, 32'd0);
        check({name, " err_drop"}, {31'd0, err}, 32'd0);
        check({name, " ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    vec_t vecs[12];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        operand  = '0;
        shamt    = '0;

        vecs[0] = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0};
        vecs[1] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
        vecs[3] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b1};
        vecs[5] = '{2'b10, 32'h7000_0000, 5'd1,  32'h3800_0000, 1'b0};
        for (int i = 6; i < 12; i++) begin
            vecs[i].op         = 2'($urandom_range(0, 3));
            vecs[i].operand    = $urandom;
            vecs[i].shamt      = 5'($urandom_range(0, 31));
            vecs[i].exp_result = model(vecs[i].op, vecs[i].operand, vecs[i].shamt);
            vecs[i].exp_err    = (vecs[i].op == 2'b11);
        end

        // Reset values.
        repeat (3) @(negedge clock);
        check("reset ready", {31'd0, ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven vectors; table expectations cross-checked against the model.
        for (int i = 0; i < 12; i++) begin
            check($sformatf("vec%0d table_vs_model", i), vecs[i].exp_result,
                  model(vecs[i].op, vecs[i].operand, vecs[i].shamt));
            issue(vecs[i].op, vecs[i].operand, vecs[i].shamt);
            collect($sformatf("vec%0d", i), 1, 0);
            sb.push_back('{vecs[i].exp_result, vecs[i].exp_err, 0, 0});
            check($sformatf("vec%0d table_result", i), result, sb[$].result);
            check($sformatf("vec%0d table_err", i), {31'd0, err}, {31'd0, sb[$].err});
            void'(sb.pop_back());
            check_pulse_end($sformatf("vec%0d", i));
        end

        // A start pulse mid-SHIFT is ignored.
        issue(2'b00, 32'h0000_0001, 5'd4);
        check("midshift busy", {31'd0, busy}, 32'd1);
        start   = 1'b1;
        op      = 2'b01;
        operand = 32'hFFFF_0000;
        shamt   = 5'd1;
        @(negedge clock);
        start   = 1'b0;
        collect("midshift_ignored", 2, 1);
        check_pulse_end("midshift_ignored");

        // Back-to-back: start during DONE with shamt 2, then a 0-latency one.
        issue(2'b01, 32'h0000_0100, 5'd3);
        collect("b2b_first", 1, 0);
        issue(2'b00, 32'h0000_0003, 5'd2);
        check("b2b done_drops", {31'd0, done}, 32'd0);
        collect("b2b_second", 1, 0);
        issue(2'b10, 32'hCAFE_F00D, 5'd0);
        check("b2b zero_done_held", {31'd0, done}, 32'd1);
        collect("b2b_zero", 1, 0);
        check_pulse_end("b2b_zero");

        // Reset on the 3rd SHIFT cycle of a shamt 10 request.
        issue(2'b00, 32'h0000_0001, 5'd10);
        repeat (2) @(negedge clock);
        check("rst_mid busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        check("rst_mid ready", {31'd0, ready}, 32'd1);
        check("rst_mid done", {31'd0, done}, 32'd0);
        check("rst_mid result", result, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 15; k++) begin
                @(negedge clock);
                if (done || busy) seen++;
            end
            check("rst_mid no_done", seen, 0);
        end
        $display("txn rst_mid: request discarded");
        issue(2'b10, 32'hF000_000F, 5'd5);
        collect("after_reset", 1, 0);
        check_pulse_end("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
